// File: rtl/resize_stream_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | resize_stream_ctrl_if : frame-memory read port + writer pixel stream  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface resize_stream_ctrl_if #(
    parameter int ADDR_W = 20
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       mem_rdata;
    logic              horizontal_sync;
    logic [7:0]        r;
    logic [7:0]        g;
    logic [7:0]        b;

    modport master (
        output mem_rd_en, mem_addr, horizontal_sync, r, g, b,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd_en, mem_addr, horizontal_sync, r, g, b,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/resize_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | resize_stream_ctrl : raster frame reader feeding the 2x upscale writer |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module resize_stream_ctrl #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int HBLANK = 16,
    parameter int ADDR_W = 20
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 hold,
    input  logic                 sink_done,
    output logic                 busy,
    output logic                 frame_done,
    resize_stream_ctrl_if.master bus
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int HB_W  = (HBLANK > 1) ? $clog2(HBLANK) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'((HBLANK > 0) ? HBLANK - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_HBLANK    = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_WAIT_SINK = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [HB_W-1:0]   hb_cnt;
    logic              drain_cnt;
    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic              row_end;
    logic              last_read;
    logic              rd_valid;
    logic              pix_valid;
    logic [23:0]       pix;

    assign row_end   = (col == COL_LAST);
    assign last_read = row_end && (row == ROW_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_READ;
            end
            ST_READ: begin
                if (!hold) begin
                    rd_en = 1'b1;
                    if (last_read)                  state_nxt = ST_DRAIN;
                    else if (row_end && HBLANK > 0) state_nxt = ST_HBLANK;
                end
            end
            ST_HBLANK: begin
                if (hb_cnt == HB_LAST) state_nxt = ST_READ;
            end
            ST_DRAIN: begin
                if (drain_cnt) state_nxt = ST_WAIT_SINK;
            end
            ST_WAIT_SINK: begin
                if (sink_done) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address runs alongside row/col instead of being computed as row*WIDTH+col.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col       <= '0;
            row       <= '0;
            hb_cnt    <= '0;
            drain_cnt <= 1'b0;
            addr      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    col  <= '0;
                    row  <= '0;
                    addr <= '0;
                end
                ST_READ: begin
                    if (rd_en) begin
                        addr <= addr + ADDR_W'(1);
                        if (row_end) begin
                            col <= '0;
                            row <= row + ROW_W'(1);
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                ST_HBLANK: begin
                    hb_cnt <= (hb_cnt == HB_LAST) ? '0 : hb_cnt + HB_W'(1);
                end
                ST_DRAIN: begin
                    drain_cnt <= ~drain_cnt;
                end
                default: begin
                end
            endcase
        end
    end

    // Two-stage valid: memory latency, then the r/g/b output register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_valid  <= 1'b0;
            pix_valid <= 1'b0;
            pix       <= '0;
        end else begin
            rd_valid  <= rd_en;
            pix_valid <= rd_valid;
            if (rd_valid) pix <= bus.mem_rdata;
        end
    end

    assign bus.mem_rd_en       = rd_en;
    assign bus.mem_addr        = addr;
    assign bus.horizontal_sync = pix_valid;
    assign bus.r               = pix[23:16];
    assign bus.g               = pix[15:8];
    assign bus.b               = pix[7:0];
    assign busy                = (state != ST_IDLE);
    assign frame_done          = (state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_resize_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_resize_stream_ctrl : directed table bench, 4x3 frame, HBLANK 2 / 0 |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_resize_stream_ctrl;

    localparam int WIN = 100;
    localparam int NV  = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic hold = 1'b0;
    logic sink_done = 1'b0;
    logic busy_a, busy_b, done_a, done_b;

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    always #5 clock = ~clock;

    resize_stream_ctrl_if #(.ADDR_W(20)) bus_a ();
    resize_stream_ctrl_if #(.ADDR_W(20)) bus_b ();

    resize_stream_ctrl #(.WIDTH(4), .HEIGHT(3), .HBLANK(2), .ADDR_W(20)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .hold(hold),
        .sink_done(sink_done), .busy(busy_a), .frame_done(done_a), .bus(bus_a)
    );

    resize_stream_ctrl #(.WIDTH(4), .HEIGHT(3), .HBLANK(0), .ADDR_W(20)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .hold(hold),
        .sink_done(sink_done), .busy(busy_b), .frame_done(done_b), .bus(bus_b)
    );

    // Frame memory word n = {n, n+1, n+2}, one cycle read latency.
    always_ff @(posedge clock) begin
        if (bus_a.mem_rd_en)
            bus_a.mem_rdata <= {bus_a.mem_addr[7:0], bus_a.mem_addr[7:0] + 8'd1, bus_a.mem_addr[7:0] + 8'd2};
        if (bus_b.mem_rd_en)
            bus_b.mem_rdata <= {bus_b.mem_addr[7:0], bus_b.mem_addr[7:0] + 8'd1, bus_b.mem_addr[7:0] + 8'd2};
    end

    logic        m_hs, m_rd, m_busy, m_fd;
    logic [19:0] m_addr;
    logic [7:0]  m_r, m_g, m_b;

    always_comb begin
        if (sel == 0) begin
            m_hs = bus_a.horizontal_sync; m_rd = bus_a.mem_rd_en; m_addr = bus_a.mem_addr;
            m_r = bus_a.r; m_g = bus_a.g; m_b = bus_a.b; m_busy = busy_a; m_fd = done_a;
        end else begin
            m_hs = bus_b.horizontal_sync; m_rd = bus_b.mem_rd_en; m_addr = bus_b.mem_addr;
            m_r = bus_b.r; m_g = bus_b.g; m_b = bus_b.b; m_busy = busy_b; m_fd = done_b;
        end
    end

    typedef struct {
        int dut;       // 0: HBLANK=2, 1: HBLANK=0
        int hold_at;
        int hold_len;
        int sink_lvl;  // sink_done held high for the whole window
        int sink_p1;   // one-cycle sink_done pulses (0 = none)
        int sink_p2;
        int start2;    // extra start pulse (0 = none)
        int e_first;
        int e_last;
        int e_gaps;
        int e_done;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_scn(input int i);
        vec_t v = vecs[i];
        int hs_n = 0, first = -1, last = -1, done_n = 0, done_at = -1, busy_n = 0;
        int pix_q[$];
        int addr_q[$];
        sel = v.dut;
        for (int rel = 0; rel < WIN; rel++) begin
            @(posedge clock); #1;
            start_a   = (v.dut == 0) && (rel == 0 || (v.start2 != 0 && rel == v.start2));
            start_b   = (v.dut == 1) && (rel == 0 || (v.start2 != 0 && rel == v.start2));
            hold      = (v.hold_len > 0) && (rel >= v.hold_at) && (rel < v.hold_at + v.hold_len);
            sink_done = (v.sink_lvl != 0) || (v.sink_p1 != 0 && rel == v.sink_p1)
                        || (v.sink_p2 != 0 && rel == v.sink_p2);
            @(negedge clock);
            if (m_hs) begin
                if (first < 0) first = rel;
                last = rel;
                hs_n++;
                pix_q.push_back(int'({m_r, m_g, m_b}));
            end
            if (m_rd) addr_q.push_back(int'(m_addr));
            if (m_busy) busy_n++;
            if (m_fd) begin
                done_n++;
                done_at = rel;
            end
        end
        start_a = 1'b0; start_b = 1'b0; hold = 1'b0; sink_done = 1'b0;
        chk($sformatf("s%0d hsync_count", i), hs_n, 12);
        chk($sformatf("s%0d read_count", i), addr_q.size(), 12);
        chk($sformatf("s%0d first_hsync", i), first, v.e_first);
        chk($sformatf("s%0d last_hsync", i), last, v.e_last);
        chk($sformatf("s%0d gap_cycles", i), last - first + 1 - hs_n, v.e_gaps);
        chk($sformatf("s%0d frame_done_count", i), done_n, 1);
        chk($sformatf("s%0d frame_done_cycle", i), done_at, v.e_done);
        chk($sformatf("s%0d busy_cycles", i), busy_n, v.e_done);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("s%0d pixel%0d", i, k), (k < pix_q.size()) ? pix_q[k] : -1,
                (k << 16) | ((k + 1) << 8) | (k + 2));
            chk($sformatf("s%0d addr%0d", i, k), (k < addr_q.size()) ? addr_q[k] : -1, k);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " mem_rd_en"}, int'(bus_a.mem_rd_en), 0);
        chk({tag, " mem_addr"}, int'(bus_a.mem_addr), 0);
        chk({tag, " hsync"}, int'(bus_a.horizontal_sync), 0);
        chk({tag, " rgb"}, int'({bus_a.r, bus_a.g, bus_a.b}), 0);
        chk({tag, " busy"}, int'(busy_a), 0);
        chk({tag, " frame_done"}, int'(done_a), 0);
    endtask

    initial begin
        int n, fd_n, busy_n;
        vecs[0] = '{0, 0, 0, 1,  0,  0,  0, 3, 18, 4, 20};
        vecs[1] = '{0, 8, 3, 1,  0,  0,  0, 3, 21, 7, 23};
        vecs[2] = '{1, 0, 0, 1,  0,  0,  0, 3, 14, 0, 16};
        vecs[3] = '{0, 0, 0, 0, 70,  0,  0, 3, 18, 4, 71};
        vecs[4] = '{0, 0, 0, 1,  0,  0,  5, 3, 18, 4, 20};
        vecs[5] = '{0, 0, 0, 1,  0,  0, 20, 3, 18, 4, 20};
        vecs[6] = '{0, 0, 0, 0, 10, 40,  0, 3, 18, 4, 41};
        vecs[7] = '{1, 1, 2, 1,  0,  0,  0, 5, 16, 0, 18};

        repeat (3) @(posedge clock);
        #1;
        chk_zero("reset");
        chk("reset busy_b", int'(busy_b), 0);
        chk("reset hsync_b", int'(bus_b.horizontal_sync), 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // sink_done while idle must not produce a frame.
        fd_n = 0; busy_n = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            sink_done = c[0];
            @(negedge clock);
            if (done_a) fd_n++;
            if (busy_a) busy_n++;
        end
        sink_done = 1'b0;
        chk("idle_sink frame_done", fd_n, 0);
        chk("idle_sink busy", busy_n, 0);

        for (int i = 0; i < NV; i++) run_scn(i);

        // Abort a frame after 5 pixels; outputs clear asynchronously.
        sel = 0; n = 0;
        for (int rel = 0; rel < 40 && n < 5; rel++) begin
            @(posedge clock); #1;
            start_a = (rel == 0);
            @(negedge clock);
            if (bus_a.horizontal_sync) n++;
        end
        start_a = 1'b0;
        chk("abort pixels_seen", n, 5);
        #1 reset = 1'b0;
        #1 chk_zero("abort");
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        sink_done = 1'b1;
        fd_n = 0; busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done_a) fd_n++;
            if (busy_a) busy_n++;
        end
        sink_done = 1'b0;
        chk("abort frame_done", fd_n, 0);
        chk("abort busy", busy_n, 0);
        run_scn(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/resize_stream_ctrl.md
# resize_stream_ctrl

Frame-level sequencer that feeds the 2x upscale output writer. It reads a source image, one 24-bit pixel per word, from a synchronous-read frame memory in raster order. It drives the writer's `horizontal_sync`/`r`/`g`/`b` pixel stream, inserting programmable horizontal blanking between rows and honouring a hold (pause) request. When the writer reports its file dump complete, the block signals frame completion.

## Interface
Parameters:
- WIDTH, 768, source pixels per row
- HEIGHT, 512, source rows per frame
- HBLANK, 16, idle cycles inserted after each row's last read (0 allowed)
- ADDR_W, 20, memory address width; must hold WIDTH*HEIGHT-1

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle request to stream one frame; ignored while busy
- hold  in  1  pause: no read issued in a cycle where hold=1
- mem_rd_en  out  1  read strobe to frame memory
- mem_addr  out  ADDR_W  read address, row*WIDTH+col
- mem_rdata  in  24  {r,g,b}, valid the cycle after mem_rd_en
- horizontal_sync  out  1  pixel-valid strobe to writer
- r, g, b  out  8 each  pixel components, meaningful when horizontal_sync=1
- sink_done  in  1  writer finished (level or pulse)
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- FSM states: IDLE, READ, HBLANK, DRAIN, WAIT_SINK, DONE.
- IDLE: row=col=0. start=1 -> READ.
- READ: each cycle with hold=0, assert mem_rd_en with mem_addr=row*WIDTH+col, then increment col.
  - On the read with col=WIDTH-1: col<=0, row<=row+1.
  - Then go to HBLANK if HBLANK>0 and this was not the last row, else READ.
  - Read of (HEIGHT-1, WIDTH-1) -> DRAIN.
- hold=1 in READ: mem_rd_en=0, counters frozen, state unchanged.
- HBLANK: counter counts HBLANK cycles regardless of hold, then -> READ.
- DRAIN: 2 cycles, flushes the output pipeline, then -> WAIT_SINK.
- WAIT_SINK: wait for sink_done=1, then -> DONE. A sink_done already high on entry is accepted in the first WAIT_SINK cycle.
- DONE: frame_done=1 for one cycle, -> IDLE.
- sink_done in any other state is ignored.
- Pixel pipeline: a valid flag shifts with the read; mem_rdata is registered into r/g/b. Every issued read produces exactly one horizontal_sync pulse, in order, and is never dropped by hold.
- Address is a registered running counter: increment by 1 per read, reset to 0 at frame start. No multiplier.

## Timing
- Reset (async, immediate) values:
  - State IDLE.
  - mem_rd_en=0, mem_addr=0, horizontal_sync=0, r=g=b=0, busy=0, frame_done=0.
  - Pipeline valid flags cleared.
- Reset mid-frame abandons the frame with no frame_done.
- start sampled in cycle t -> busy=1 and first mem_rd_en in cycle t+1 (if hold=0).
- Read in cycle t -> horizontal_sync=1 with that pixel in cycle t+2.
- With no hold, horizontal_sync is continuous for WIDTH cycles per row, followed by exactly HBLANK low cycles.
- Last horizontal_sync of the frame occurs in the second DRAIN cycle.
- frame_done rises one cycle after sink_done is sampled in WAIT_SINK. busy falls with frame_done's cycle ending; frame_done and busy are both high in DONE.
- start asserted in DONE is ignored. The earliest new frame starts from start in the following IDLE cycle.
- Widths: col counts to WIDTH-1, row to HEIGHT-1, HBLANK counter to HBLANK-1; all sized via $clog2 with a minimum of 1 bit.

## Test plan
- WIDTH=4, HEIGHT=3, HBLANK=2, memory word n = {n,n+1,n+2}, start at cycle 10, hold=0:
  - 12 horizontal_sync pulses, r=0..11 in order.
  - Pattern per row: 4 high, 2 low; first pulse at cycle 13.
  - mem_addr sequence 0..11.
- Same config, hold=1 for 3 cycles mid-row 1 -> 3 extra gap cycles in the stream, still 12 pixels, no duplicates, no loss.
- HBLANK=0 -> 12 consecutive horizontal_sync cycles; state never enters HBLANK.
- sink_done held high before the frame ends -> frame_done pulses exactly 1 cycle after first WAIT_SINK cycle. sink_done delayed 50 cycles -> busy stays 1, frame_done fires 1 cycle after it.
- reset low after 5 pixels -> all outputs 0 immediately, no frame_done. A new start after reset streams from address 0.
- start pulses while busy, and sink_done pulses in IDLE -> no effect; exactly one frame_done per accepted start.
